// File: rtl/conv_window_scheduler.sv
// Window sequencer for the float16 convolution datapath: walks kernel windows
// (input channel innermost, then column, row, output channel) and hands each one to the MAC array.
module conv_window_scheduler #(
  parameter int data_width     = 16,
  parameter int input_channel  = 2,
  parameter int output_channel = 1,
  parameter int image_length   = 4,
  parameter int image_width    = 4,
  parameter int weight_length  = 3,
  parameter int weight_width   = 3,
  parameter int stride         = 1,
  parameter int result_length  = 2,
  parameter int result_width   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  conv_en,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [data_width-1:0] anchor_l,
  output logic [data_width-1:0] anchor_c,
  output logic [7:0]            ch_idx,
  output logic [7:0]            oc_idx,
  output logic                  acc_clear,
  output logic                  acc_last,
  input  logic                  mac_done,
  output logic                  result_valid,
  output logic [7:0]            res_l,
  output logic [7:0]            res_c,
  output logic [7:0]            res_oc,
  output logic                  busy,
  output logic                  conv_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [data_width-1:0] stride_step     = data_width'(stride);
  localparam logic [data_width-1:0] last_col_anchor = data_width'((result_width - 1) * stride);
  localparam logic [data_width-1:0] last_row_anchor = data_width'((result_length - 1) * stride);
  localparam logic [7:0]            last_ch         = 8'(input_channel - 1);
  localparam logic [7:0]            last_oc         = 8'(output_channel - 1);

  state_t     state_r;
  logic [7:0] res_row_r;
  logic [7:0] res_col_r;
  logic       ch_wrap_s;
  logic       col_wrap_s;
  logic       row_wrap_s;
  logic       oc_wrap_s;

  assign ch_wrap_s  = (ch_idx == last_ch);
  assign col_wrap_s = (anchor_c == last_col_anchor);
  assign row_wrap_s = (anchor_l == last_row_anchor);
  assign oc_wrap_s  = (oc_idx == last_oc);

  // Sequencer FSM; output-pixel row/col are counted alongside the anchors so no divider is needed.
  always_ff @(posedge clk) begin
    if (!reset || !conv_en) begin
      state_r      <= IDLE;
      win_valid    <= 1'b0;
      anchor_l     <= {data_width{1'b0}};
      anchor_c     <= {data_width{1'b0}};
      ch_idx       <= 8'd0;
      oc_idx       <= 8'd0;
      acc_clear    <= 1'b0;
      acc_last     <= 1'b0;
      result_valid <= 1'b0;
      res_l        <= 8'd0;
      res_c        <= 8'd0;
      res_oc       <= 8'd0;
      busy         <= 1'b0;
      conv_done    <= 1'b0;
      res_row_r    <= 8'd0;
      res_col_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          result_valid <= 1'b0;
          state_r      <= ISSUE;
          win_valid    <= 1'b1;
          busy         <= 1'b1;
          acc_clear    <= 1'b1;
          acc_last     <= (last_ch == 8'd0);
        end
        ISSUE: begin
          result_valid <= 1'b0;
          if (win_ready) begin
            state_r   <= WAIT;
            win_valid <= 1'b0;
          end
        end
        WAIT: begin
          result_valid <= 1'b0;
          if (mac_done) begin
            state_r <= NEXT;
          end
        end
        NEXT: begin
          result_valid <= ch_wrap_s;
          if (ch_wrap_s) begin
            res_l  <= res_row_r;
            res_c  <= res_col_r;
            res_oc <= oc_idx;
          end
          // Final window: descriptor fields keep their last values while DONE.
          if (ch_wrap_s && col_wrap_s && row_wrap_s && oc_wrap_s) begin
            state_r   <= DONE;
            busy      <= 1'b0;
            conv_done <= 1'b1;
          end else begin
            state_r   <= ISSUE;
            win_valid <= 1'b1;
            if (!ch_wrap_s) begin
              ch_idx    <= ch_idx + 8'd1;
              acc_clear <= 1'b0;
              acc_last  <= ((ch_idx + 8'd1) == last_ch);
            end else begin
              ch_idx    <= 8'd0;
              acc_clear <= 1'b1;
              acc_last  <= (last_ch == 8'd0);
              if (!col_wrap_s) begin
                anchor_c  <= anchor_c + stride_step;
                res_col_r <= res_col_r + 8'd1;
              end else begin
                anchor_c  <= {data_width{1'b0}};
                res_col_r <= 8'd0;
                if (!row_wrap_s) begin
                  anchor_l  <= anchor_l + stride_step;
                  res_row_r <= res_row_r + 8'd1;
                end else begin
                  anchor_l  <= {data_width{1'b0}};
                  res_row_r <= 8'd0;
                  oc_idx    <= oc_idx + 8'd1;
                end
              end
            end
          end
        end
        DONE: begin
          result_valid <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          win_valid    <= 1'b0;
          busy         <= 1'b0;
          conv_done    <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: default 4x4/3x3 layer on instance 0,
// stride-2 two-output-channel layer on instance 1, selected by sel.
module tb_conv_window_scheduler;

  typedef struct {
    int l; int c; int ch; int oc;
    int clr; int last; int rv;
    int rl; int rc; int roc;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, conv_en, win_ready, mac_done, sel;

  logic        win_valid_v [2];
  logic [15:0] anchor_l_v  [2];
  logic [15:0] anchor_c_v  [2];
  logic [7:0]  ch_idx_v    [2];
  logic [7:0]  oc_idx_v    [2];
  logic        acc_clear_v [2];
  logic        acc_last_v  [2];
  logic        rv_v        [2];
  logic [7:0]  res_l_v     [2];
  logic [7:0]  res_c_v     [2];
  logic [7:0]  res_oc_v    [2];
  logic        busy_v      [2];
  logic        done_v      [2];
  logic        en_v        [2];
  logic        rdy_v       [2];
  logic        md_v        [2];

  assign en_v[0]  = conv_en & ~sel;
  assign en_v[1]  = conv_en & sel;
  assign rdy_v[0] = win_ready & ~sel;
  assign rdy_v[1] = win_ready & sel;
  assign md_v[0]  = mac_done & ~sel;
  assign md_v[1]  = mac_done & sel;

  conv_window_scheduler u_dflt (
    .clk(clk), .reset(reset), .conv_en(en_v[0]),
    .win_valid(win_valid_v[0]), .win_ready(rdy_v[0]),
    .anchor_l(anchor_l_v[0]), .anchor_c(anchor_c_v[0]),
    .ch_idx(ch_idx_v[0]), .oc_idx(oc_idx_v[0]),
    .acc_clear(acc_clear_v[0]), .acc_last(acc_last_v[0]),
    .mac_done(md_v[0]), .result_valid(rv_v[0]),
    .res_l(res_l_v[0]), .res_c(res_c_v[0]), .res_oc(res_oc_v[0]),
    .busy(busy_v[0]), .conv_done(done_v[0])
  );

  conv_window_scheduler #(
    .input_channel(1), .output_channel(2), .image_length(5), .image_width(5),
    .weight_length(3), .weight_width(3), .stride(2), .result_length(2), .result_width(2)
  ) u_strd (
    .clk(clk), .reset(reset), .conv_en(en_v[1]),
    .win_valid(win_valid_v[1]), .win_ready(rdy_v[1]),
    .anchor_l(anchor_l_v[1]), .anchor_c(anchor_c_v[1]),
    .ch_idx(ch_idx_v[1]), .oc_idx(oc_idx_v[1]),
    .acc_clear(acc_clear_v[1]), .acc_last(acc_last_v[1]),
    .mac_done(md_v[1]), .result_valid(rv_v[1]),
    .res_l(res_l_v[1]), .res_c(res_c_v[1]), .res_oc(res_oc_v[1]),
    .busy(busy_v[1]), .conv_done(done_v[1])
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  win_t dflt_tbl [8];
  win_t strd_tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " win_valid"}, 32'(win_valid_v[sel]), 32'd0);
    chk({nm, " busy"}, 32'(busy_v[sel]), 32'd0);
    chk({nm, " conv_done"}, 32'(done_v[sel]), 32'd0);
    chk({nm, " result_valid"}, 32'(rv_v[sel]), 32'd0);
    chk({nm, " anchor_l"}, 32'(anchor_l_v[sel]), 32'd0);
    chk({nm, " anchor_c"}, 32'(anchor_c_v[sel]), 32'd0);
    chk({nm, " ch_idx"}, 32'(ch_idx_v[sel]), 32'd0);
    chk({nm, " oc_idx"}, 32'(oc_idx_v[sel]), 32'd0);
    chk({nm, " acc_clear"}, 32'(acc_clear_v[sel]), 32'd0);
    chk({nm, " acc_last"}, 32'(acc_last_v[sel]), 32'd0);
    chk({nm, " res_l"}, 32'(res_l_v[sel]), 32'd0);
    chk({nm, " res_c"}, 32'(res_c_v[sel]), 32'd0);
    chk({nm, " res_oc"}, 32'(res_oc_v[sel]), 32'd0);
  endtask

  task automatic chk_desc(input string nm, input win_t w);
    chk({nm, " win_valid"}, 32'(win_valid_v[sel]), 32'd1);
    chk({nm, " anchor_l"}, 32'(anchor_l_v[sel]), 32'(w.l));
    chk({nm, " anchor_c"}, 32'(anchor_c_v[sel]), 32'(w.c));
    chk({nm, " ch_idx"}, 32'(ch_idx_v[sel]), 32'(w.ch));
    chk({nm, " oc_idx"}, 32'(oc_idx_v[sel]), 32'(w.oc));
    chk({nm, " acc_clear"}, 32'(acc_clear_v[sel]), 32'(w.clr));
    chk({nm, " acc_last"}, 32'(acc_last_v[sel]), 32'(w.last));
  endtask

  // Enter in the ISSUE cycle; leave in the cycle after NEXT (result_valid cycle).
  task automatic do_window(input win_t w, input int stall);
    chk_desc("issue", w);
    chk("issue busy", 32'(busy_v[sel]), 32'd1);
    for (int i = 0; i < stall; i++) begin
      win_ready = 1'b0;
      mac_done  = (i == 1);
      tick();
      mac_done  = 1'b0;
      chk_desc("stall", w);
      chk("stall result_valid", 32'(rv_v[sel]), 32'd0);
    end
    win_ready = 1'b1;
    tick();
    chk("wait win_valid", 32'(win_valid_v[sel]), 32'd0);
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    chk("next busy", 32'(busy_v[sel]), 32'd1);
    chk("next result_valid", 32'(rv_v[sel]), 32'd0);
    tick();
    chk("result_valid", 32'(rv_v[sel]), 32'(w.rv));
    if (w.rv != 0) begin
      chk("res_l", 32'(res_l_v[sel]), 32'(w.rl));
      chk("res_c", 32'(res_c_v[sel]), 32'(w.rc));
      chk("res_oc", 32'(res_oc_v[sel]), 32'(w.roc));
    end
  endtask

  task automatic start_layer();
    conv_en = 1'b1;
    cyc = 0;
    tick();
  endtask

  initial begin
    //             l  c  ch oc clr last rv rl rc roc
    dflt_tbl[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    dflt_tbl[1] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
    dflt_tbl[2] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    dflt_tbl[3] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0};
    dflt_tbl[4] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    dflt_tbl[5] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
    dflt_tbl[6] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    dflt_tbl[7] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    strd_tbl[0] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    strd_tbl[1] = '{0, 2, 0, 0, 1, 1, 1, 0, 1, 0};
    strd_tbl[2] = '{2, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    strd_tbl[3] = '{2, 2, 0, 0, 1, 1, 1, 1, 1, 0};
    strd_tbl[4] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    strd_tbl[5] = '{0, 2, 0, 1, 1, 1, 1, 0, 1, 1};
    strd_tbl[6] = '{2, 0, 0, 1, 1, 1, 1, 1, 0, 1};
    strd_tbl[7] = '{2, 2, 0, 1, 1, 1, 1, 1, 1, 1};

    sel = 1'b0; reset = 1'b0; conv_en = 1'b0; win_ready = 1'b1; mac_done = 1'b0;
    tick(); tick();
    chk_idle("reset");
    reset = 1'b1;

    // Spurious mac_done while idle must not start anything.
    mac_done = 1'b1;
    tick(); tick(); tick();
    mac_done = 1'b0;
    chk_idle("idle spurious mac_done");

    // Default layer, no stalls.
    start_layer();
    chk("start latency cycle", 32'(cyc), 32'd1);
    for (int k = 0; k < 8; k++) do_window(dflt_tbl[k], 0);
    chk("dflt done cycle", 32'(cyc), 32'd25);
    chk("dflt conv_done", 32'(done_v[sel]), 32'd1);
    chk("dflt done busy", 32'(busy_v[sel]), 32'd0);
    chk("dflt done win_valid", 32'(win_valid_v[sel]), 32'd0);
    chk("dflt hold anchor_l", 32'(anchor_l_v[sel]), 32'd1);
    chk("dflt hold anchor_c", 32'(anchor_c_v[sel]), 32'd1);
    chk("dflt hold ch_idx", 32'(ch_idx_v[sel]), 32'd1);
    tick();
    chk("dflt done held", 32'(done_v[sel]), 32'd1);
    chk("dflt done no extra result", 32'(rv_v[sel]), 32'd0);
    conv_en = 1'b0;
    tick();
    chk_idle("dflt after conv_en low");

    // Backpressure on window 3 with a spurious mac_done inside the stall.
    start_layer();
    for (int k = 0; k < 8; k++) do_window(dflt_tbl[k], (k == 2) ? 5 : 0);
    chk("bp done cycle", 32'(cyc), 32'd30);
    chk("bp conv_done", 32'(done_v[sel]), 32'd1);
    conv_en = 1'b0;
    tick();

    // Abort during WAIT of window 4, with a mac_done arriving at the same edge.
    start_layer();
    for (int k = 0; k < 3; k++) do_window(dflt_tbl[k], 0);
    chk_desc("abort w4 issue", dflt_tbl[3]);
    tick();
    chk("abort wait win_valid", 32'(win_valid_v[sel]), 32'd0);
    conv_en = 1'b0;
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    chk_idle("abort");
    tick();
    chk_idle("abort settled");
    start_layer();
    chk_desc("restart", dflt_tbl[0]);
    conv_en = 1'b0;
    tick();

    // Reset asserted while in NEXT on a channel wrap.
    start_layer();
    do_window(dflt_tbl[0], 0);
    tick();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    reset = 1'b0;
    conv_en = 1'b0;
    tick();
    chk_idle("reset in NEXT");
    reset = 1'b1;
    tick();
    chk_idle("after reset in NEXT");

    // Stride-2, single input channel, two output channels.
    sel = 1'b1;
    tick();
    start_layer();
    for (int k = 0; k < 8; k++) do_window(strd_tbl[k], 0);
    chk("strd done cycle", 32'(cyc), 32'd25);
    chk("strd conv_done", 32'(done_v[sel]), 32'd1);
    conv_en = 1'b0;
    tick();
    chk_idle("strd after conv_en low");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
